// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter slice: FSM states, ALU opcodes, requester count.
// Build option: ALU_ARB_RR_EN selects round-robin instead of fixed-priority grant.
package alu_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    function automatic logic [NUM_REQ-1:0] idx2onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arb_grant2.sv
// Combinational two-way grant. ALU_ARB_RR_EN: on a tie the requester not granted
// last wins; otherwise requester 0 always wins a tie.
module alu_arb_grant2
    import alu_arb_pkg::*;
(
`ifdef ALU_ARB_RR_EN
    input  logic               last,
`endif
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = req_valid;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            gnt = last ? 2'b01 : 2'b10;
`else
            gnt = 2'b01;
`endif
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters (IDLE/EXEC/RESP sequencer).
// Build option: ALU_ARB_RR_EN enables round-robin arbitration and the last-grant pointer.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_op1_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_op2_i,
    input  logic [NUM_REQ-1:0][2:0]             req_ctrl_i,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    input  logic [NUM_REQ-1:0]                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0]               rsp_data_o,
    output logic                                rsp_zero_o,
    output logic [DATA_WIDTH-1:0]               aluop1_o,
    output logic [DATA_WIDTH-1:0]               aluop2_o,
    output logic [2:0]                          alucontrol_o,
    input  logic [DATA_WIDTH-1:0]               aluout_i,
    input  logic                                zero_i
);

    state_t             state;
    logic               grant;
    logic [NUM_REQ-1:0] gnt;
    logic               gidx;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    alu_arb_grant2 u_grant (
        .last      (last_grant),
        .req_valid (req_valid_i),
        .gnt       (gnt)
    );
`else
    alu_arb_grant2 u_grant (
        .req_valid (req_valid_i),
        .gnt       (gnt)
    );
`endif

    assign gidx = gnt[1];

    // Ready is the live grant while idle, so acceptance happens in the request cycle.
    assign req_ready_o = (state == IDLE && !rst) ? gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            rsp_valid_o  <= '0;
            rsp_data_o   <= '0;
            rsp_zero_o   <= 1'b0;
            aluop1_o     <= '0;
            aluop2_o     <= '0;
            alucontrol_o <= '0;
`ifdef ALU_ARB_RR_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        aluop1_o     <= req_op1_i[gidx];
                        aluop2_o     <= req_op2_i[gidx];
                        alucontrol_o <= req_ctrl_i[gidx];
                        grant        <= gidx;
`ifdef ALU_ARB_RR_EN
                        last_grant   <= gidx;
`endif
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_o  <= aluout_i;
                    rsp_zero_o  <= zero_i;
                    rsp_valid_o <= idx2onehot(grant);
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i[grant]) begin
                        rsp_valid_o <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model plus directed literal checks.
// Honours ALU_ARB_RR_EN for expected arbitration order.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][31:0] req_op1_i;
    logic [1:0][31:0] req_op2_i;
    logic [1:0][2:0]  req_ctrl_i;
    logic [1:0]       rsp_valid_o;
    logic [1:0]       rsp_ready_i;
    logic [31:0]      rsp_data_o;
    logic             rsp_zero_o;
    logic [31:0]      aluop1_o;
    logic [31:0]      aluop2_o;
    logic [2:0]       alucontrol_o;
    logic [31:0]      aluout_i;
    logic             zero_i;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op1_i    (req_op1_i),
        .req_op2_i    (req_op2_i),
        .req_ctrl_i   (req_ctrl_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_zero_o   (rsp_zero_o),
        .aluop1_o     (aluop1_o),
        .aluop2_o     (aluop2_o),
        .alucontrol_o (alucontrol_o),
        .aluout_i     (aluout_i),
        .zero_i       (zero_i)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // External ALU stub
    always_comb begin
        aluout_i = alu_f(alucontrol_o, aluop1_o, aluop2_o);
        zero_i   = (aluout_i == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] v, input bit last);
        if (v == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            return last ? 0 : 1;
`else
            return 0;
`endif
        end
        return v[1] ? 1 : 0;
    endfunction

    // Model: one outstanding transaction; response visible from the 2nd cycle after acceptance.
    bit          m_busy = 0;
    int          m_age = 0;
    int          m_gnt = 0;
    bit          m_last = 1;
    logic [31:0] m_op1 = '0;
    logic [31:0] m_op2 = '0;
    logic [2:0]  m_ctrl = '0;

    int          obs_g[$];
    logic [31:0] obs_d[$];
    bit          obs_z[$];

    always @(negedge clk) begin : model
        logic [1:0]  er;
        logic [1:0]  ev;
        logic [31:0] res;
        int          w;
        if (rst) begin
            m_busy = 0; m_age = 0; m_gnt = 0; m_last = 1;
            m_op1 = '0; m_op2 = '0; m_ctrl = '0;
        end
        w  = 0;
        er = 2'b00;
        if (!rst && !m_busy && req_valid_i != 2'b00) begin
            w  = pick(req_valid_i, m_last);
            er = (w == 1) ? 2'b10 : 2'b01;
        end
        ev  = (m_busy && m_age >= 2) ? ((m_gnt == 1) ? 2'b10 : 2'b01) : 2'b00;
        res = alu_f(m_ctrl, m_op1, m_op2);
        chk("req_ready", 32'(req_ready_o), 32'(er));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(ev));
        if (ev != 2'b00) begin
            chk("rsp_data", rsp_data_o, res);
            chk("rsp_zero", 32'(rsp_zero_o), 32'(res == 32'd0));
        end
        if (rst) begin
            chk("rst_data", rsp_data_o, 32'd0);
            chk("rst_zero", 32'(rsp_zero_o), 32'd0);
        end
        chk("aluop1", aluop1_o, m_op1);
        chk("aluop2", aluop2_o, m_op2);
        chk("alucontrol", 32'(alucontrol_o), 32'(m_ctrl));
        if ((rsp_valid_o & rsp_ready_i) != 2'b00) begin
            obs_g.push_back(rsp_valid_o[1] ? 1 : 0);
            obs_d.push_back(rsp_data_o);
            obs_z.push_back(rsp_zero_o);
        end
        if (!rst) begin
            if (m_busy) begin
                if (m_age >= 2 && rsp_ready_i[m_gnt]) m_busy = 0;
                else m_age++;
            end else if (er != 2'b00) begin
                m_busy = 1; m_age = 1; m_gnt = w; m_last = w[0];
                m_op1 = req_op1_i[w]; m_op2 = req_op2_i[w]; m_ctrl = req_ctrl_i[w];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_valid_i = 2'b00;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        req_op1_i[r]   = a;
        req_op2_i[r]   = b;
        req_ctrl_i[r]  = c;
        req_valid_i[r] = 1'b1;
    endtask

    // Drop each request once accepted; run until target responses seen and no request pending.
    task automatic drain(input int target, input int budget);
        logic [1:0] acc;
        int k = 0;
        while ((obs_d.size() < target || req_valid_i != 2'b00) && k < budget) begin
            @(negedge clk);
            acc = req_ready_o;
            tick;
            req_valid_i &= ~acc;
            k++;
        end
        chk("drain_in_budget", 32'(k < budget), 32'd1);
    endtask

    task automatic one_op(input string name, input int r, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ed, input bit ez);
        int s = obs_d.size();
        set_req(r, c, a, b);
        drain(s + 1, 20);
        chk({name, "_grant"}, 32'(obs_g[s]), 32'(r));
        chk({name, "_data"}, obs_d[s], ed);
        chk({name, "_zero"}, 32'(obs_z[s]), 32'(ez));
    endtask

    initial begin
        int s;
        int n;
        int k;
        int exp_ord[4];
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b11;
        req_op1_i   = '0;
        req_op2_i   = '0;
        req_ctrl_i  = '0;
        tick;
        tick;
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_aluctrl", 32'(alucontrol_o), 32'd0);
        rst = 1'b0;

        // Single ADD with latency pinned by hand
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        @(negedge clk); chk("add_accept", 32'(req_ready_o), 32'd1);
        tick; req_valid_i = 2'b00;
        @(negedge clk); chk("add_exec_novalid", 32'(rsp_valid_o), 32'd0);
        chk("add_aluop1", aluop1_o, 32'd5);
        @(negedge clk); chk("add_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("add_data", rsp_data_o, 32'd12);
        chk("add_zero", 32'(rsp_zero_o), 32'd0);
        tick;

        // Tie right after reset: requester 0 first
        do_reset;
        s = obs_d.size();
        set_req(0, ALU_SUB, 32'd3, 32'd3);
        set_req(1, ALU_OR, 32'h0F0, 32'h00F);
        drain(s + 2, 40);
        chk("tie_first_grant", 32'(obs_g[s]), 32'd0);
        chk("tie_first_data", obs_d[s], 32'd0);
        chk("tie_first_zero", 32'(obs_z[s]), 32'd1);
        chk("tie_second_grant", 32'(obs_g[s+1]), 32'd1);
        chk("tie_second_data", obs_d[s+1], 32'hFF);

        // Sustained contention over 4 accepts
`ifdef ALU_ARB_RR_EN
        exp_ord = '{0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 0, 0};
`endif
        s = obs_d.size();
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        set_req(1, ALU_ADD, 32'd2, 32'd2);
        n = 0;
        k = 0;
        while (n < 4 && k < 100) begin
            @(negedge clk);
            if (req_ready_o != 2'b00) n++;
            tick;
            k++;
        end
        req_valid_i = 2'b00;
        chk("contend_accepts", 32'(n), 32'd4);
        drain(s + 4, 60);
        for (int i = 0; i < 4; i++) begin
            chk("contend_order", 32'(obs_g[s+i]), 32'(exp_ord[i]));
            chk("contend_data", obs_d[s+i], (exp_ord[i] == 0) ? 32'd2 : 32'd4);
        end

        // Backpressure on requester 0, requester 1 waiting and its rsp_ready ignored
        s = obs_d.size();
        rsp_ready_i = 2'b10;
        set_req(0, ALU_ADD, 32'd100, -32'sd100);
        @(negedge clk); chk("bp_accept", 32'(req_ready_o), 32'd1);
        tick; req_valid_i = 2'b00;
        set_req(1, ALU_ADD, 32'd1, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_data", rsp_data_o, 32'd0);
            chk("bp_zero", 32'(rsp_zero_o), 32'd1);
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
        end
        tick;
        rsp_ready_i = 2'b11;
        drain(s + 2, 40);
        chk("bp_first_grant", 32'(obs_g[s]), 32'd0);
        chk("bp_second_grant", 32'(obs_g[s+1]), 32'd1);
        chk("bp_second_data", obs_d[s+1], 32'd2);

        // Signed compare and undefined opcode
        one_op("slt_neg", 0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        one_op("slt_pos", 1, ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        one_op("ctrl111", 0, 3'b111, 32'd9, 32'd9, 32'd0, 1'b1);
        one_op("and", 1, ALU_AND, 32'hFF00, 32'h0FF0, 32'h0F00, 1'b0);

        // Reset during EXEC drops the transaction
        s = obs_d.size();
        set_req(0, ALU_ADD, 32'd9, 32'd9);
        @(negedge clk); chk("rexec_accept", 32'(req_ready_o), 32'd1);
        tick; req_valid_i = 2'b00;
        rst = 1'b1;
        #1;
        chk("rexec_req_ready", 32'(req_ready_o), 32'd0);
        chk("rexec_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rexec_aluop1", aluop1_o, 32'd0);
        chk("rexec_aluop2", aluop2_o, 32'd0);
        chk("rexec_data", rsp_data_o, 32'd0);
        tick;
        tick;
        rst = 1'b0;
        repeat (6) tick;
        chk("rexec_no_rsp", 32'(obs_d.size()), 32'(s));
        one_op("post_rst_add", 0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
